// File: rtl/char_pkg.sv
// Shared character constants and types for the receive-side character buffer.
package char_pkg;

  typedef logic [7:0] char_t;

  localparam char_t CHAR_NUL = 8'h00;
  localparam char_t CHAR_LF  = 8'h0A;
  localparam char_t CHAR_CR  = 8'h0D;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x 8 register array with one synchronous write port and an asynchronous read port.
module fifo_ram
  import char_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  char_t         wdata,
  input  logic [AW-1:0] raddr,
  output char_t         rdata
);

  char_t mem [DEPTH];

  // Write the incoming byte at the write pointer; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/char_rx_fifo.sv
// Receive character FIFO feeding the UART char_in/read pair; char_out reads 0x00 when empty.
// Optional CR->LF folding is enabled by defining CHAR_RX_FIFO_CRLF_EN.
module char_rx_fifo
  import char_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     APB_PCLK,
  input  logic                     APB_PRESET,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     full,
  output logic [7:0]               char_out,
  input  logic                     read,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [CNT_WIDTH-1:0] drop_cnt_r;
  char_t                store_byte_s;
  char_t                rdata_s;
  logic                 skip_s;
  logic                 push_req_s;
  logic                 pop_ok_s;
  logic                 push_ok_s;
  logic                 drop_s;
  logic                 full_s;
  logic                 empty_s;

`ifdef CHAR_RX_FIFO_CRLF_EN
  logic                 last_was_cr_r;

  // CR is stored as LF, and an LF right after a CR is swallowed.
  always_comb begin
    store_byte_s = in_data;
    skip_s       = 1'b0;
    if (in_data == CHAR_CR) begin
      store_byte_s = CHAR_LF;
    end else begin
      store_byte_s = in_data;
    end
    skip_s = last_was_cr_r && (in_data == CHAR_LF);
  end

  // Remember whether the previous cycle carried a CR byte.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      last_was_cr_r <= 1'b0;
    end else begin
      last_was_cr_r <= in_valid && (in_data == CHAR_CR);
    end
  end
`else
  assign store_byte_s = in_data;
  assign skip_s       = 1'b0;
`endif

  assign empty_s    = (level_r == {LW{1'b0}});
  assign full_s     = (level_r == LW'(DEPTH));
  assign push_req_s = in_valid && (in_data != CHAR_NUL) && !skip_s;
  assign pop_ok_s   = read && !empty_s;
  // A pop from a full FIFO frees the slot the simultaneous push needs.
  assign push_ok_s  = push_req_s && (!full_s || pop_ok_s);
  assign drop_s     = push_req_s && full_s && !pop_ok_s;

  fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (APB_PCLK),
    .we    (push_ok_s && !APB_PRESET),
    .waddr (wr_ptr_r),
    .wdata (store_byte_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Pointer, occupancy and saturating drop-counter bookkeeping.
  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_r + LW'(push_ok_s) - LW'(pop_ok_s);
      if (drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign char_out = empty_s ? CHAR_NUL : rdata_s;
  assign full     = full_s;
  assign level    = level_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: doc/char_rx_fifo.md
Name: char_rx_fifo

Overview:
- Receive-side character buffer feeding the simulation UART's `char_in`/`read` pair.
- Accepts bytes from the host-side source (testbench keyboard/file reader), stores them in a circular FIFO and presents the head byte as `char_out`.
- `char_out` is 0x00 when empty, which the UART reports as "no data".
- Pops the head on the UART's one-cycle `read` pulse.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 8, width of saturating drop counter.

Ports:
- APB_PCLK  input  1  system clock; all state updates on rising edge.
- APB_PRESET  input  1  synchronous, active-high reset.
- in_valid  input  1  host byte strobe; one byte per cycle, no backpressure.
- in_data  input  8  host byte.
- full  output  1  FIFO full; advisory to host.
- char_out  output  8  head byte, or 0x00 when empty; connects to UART `char_in`.
- read  input  1  pop pulse from UART `read`.
- level  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  CNT_WIDTH  bytes discarded due to full.

Behaviour:
- Reset, synchronous and active-high:
  - wr_ptr, rd_ptr and level = 0; drop_cnt = 0.
  - char_out = 0x00; full = 0.
  - Storage contents are don't-care.
  - Reset wins over a simultaneous push or pop. A byte presented in the reset cycle is lost and not counted.
- Storage:
  - DEPTH x 8 register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is tracked separately: empty = (level==0), full = (level==DEPTH).
- char_out:
  - Combinational: mem[rd_ptr] when level != 0, else 0x00.
  - A byte pushed in cycle N is visible on char_out in cycle N+1 (one-cycle latency).
- Push (in_valid=1):
  - in_data==0x00: discarded, not stored, not counted. A NUL cannot be distinguished from "empty" downstream.
  - Else if not full: mem[wr_ptr] <= in_data, wr_ptr++.
  - Else (full): byte dropped; drop_cnt increments and saturates at all-ones.
- Pop (read=1):
  - If level != 0: rd_ptr++.
  - If empty: ignored, no state change.
  - Each high cycle of read pops once. The UART guarantees a single-cycle pulse per data-register read.
- Simultaneous push and pop:
  - Non-empty, not full: both occur, level unchanged.
  - Full: the pop frees a slot in the same cycle, so the push is accepted, level stays DEPTH and drop_cnt is unchanged.
  - Empty: the pop is ignored and the push is accepted, level = 1.
- level arithmetic: level_next = level + push_ok - pop_ok, where push_ok and pop_ok are the qualified events above.
- No other state machine. Two-state implicit mode (empty / non-empty) derives from level.

Optional Feature:
- Macro: CHAR_RX_FIFO_CRLF_EN.
- Defined:
  - Incoming 0x0D (CR) is stored as 0x0A (LF).
  - A 0x0A arriving in the cycle immediately after a translated CR is discarded, not counted.
  - One register `last_was_cr` is cleared by reset, on any other byte, or when in_valid=0.
- Undefined: bytes are stored verbatim and no extra register exists.

Decomposition:
- Shared package `char_pkg`:
  - Constants CHAR_NUL=8'h00, CHAR_LF=8'h0A, CHAR_CR=8'h0D.
  - Typedef `char_t` (8-bit).
- Sub-module `fifo_ram`: DEPTH x 8 register array, single write port, asynchronous read port. The pointer/level/drop logic stays in char_rx_fifo.

Test Plan:
- Reset then idle -> char_out=0x00, level=0, full=0, drop_cnt=0; a read pulse while empty leaves all unchanged.
- Push 0x41 in cycle 0 -> char_out=0x00 in cycle 0, 0x41 in cycle 1; read pulse in cycle 3 -> char_out=0x00 and level=0 in cycle 4.
- Fill: push 0x30..0x3F (16 bytes, DEPTH=16) -> full=1, level=16. Push 0x40 and 0x41 -> drop_cnt=2. Drain 16 pops -> char_out sequence is 0x30..0x3F, then 0x00; pointers wrapped.
- When full, push 0x50 and pop in the same cycle -> level stays 16, drop_cnt unchanged; after draining, 0x50 is the last byte out.
- Push 0x00 between 0x61 and 0x62 -> only 0x61 and 0x62 are stored, level=2, drop_cnt=0.
- With CHAR_RX_FIFO_CRLF_EN defined, push 0x0D, 0x0A, 0x0A on consecutive cycles -> stored 0x0A, 0x0A (level=2). With the macro undefined -> stored 0x0D, 0x0A, 0x0A.
